// File: rtl/hsum_pkg.sv
// Shared definitions for the harmonic-sum engine (datapath and sequencer FSM).
// Default widths, derived accumulator width, common typedefs and the saturation constant.
package hsum_pkg;

    localparam int HSUM_N_W     = 8;
    localparam int HSUM_FRAC_W  = 16;
    localparam int HSUM_INT_W   = 4;
    localparam int HSUM_ACC_W   = HSUM_INT_W + HSUM_FRAC_W;

    typedef logic [HSUM_N_W-1:0]   n_t;
    typedef logic [HSUM_FRAC_W:0]  term_t;
    typedef logic [HSUM_ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = '1;

endpackage

// File: rtl/hsum_recip_rom.sv
// Combinational reciprocal table: recip = floor(2^FRAC_W / addr), entry 0 = 0.
// Contents are produced at elaboration by a constant function.
module hsum_recip_rom #(
    parameter int N_W    = 8,
    parameter int FRAC_W = 16
) (
    input  logic [N_W-1:0]  addr,
    output logic [FRAC_W:0] recip
);

    localparam int DEPTH = 2 ** N_W;

    function automatic logic [FRAC_W:0] recip_val(input int unsigned idx);
        longint unsigned one_q;
        one_q = 64'(1) << FRAC_W;
        if (idx == 0) begin
            return '0;
        end
        return (FRAC_W+1)'(one_q / 64'(idx));
    endfunction

    logic [FRAC_W:0] table_mem [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        localparam logic [FRAC_W:0] ENTRY = recip_val(g);
        assign table_mem[g] = ENTRY;
    end

    assign recip = table_mem[addr];

endmodule

// File: rtl/harmonic_datapath.sv
// Datapath of the harmonic-sum engine: n register, term counter, accumulator, compare and done.
// Define HSUM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module harmonic_datapath
    import hsum_pkg::*;
#(
    parameter  int N_W    = HSUM_N_W,
    parameter  int FRAC_W = HSUM_FRAC_W,
    parameter  int INT_W  = HSUM_INT_W,
    localparam int ACC_W  = INT_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_W-1:0]   n_in,
    input  logic             reset_datapath,
    input  logic             reset_n,
    input  logic             n_en,
    input  logic             add_en,
    input  logic             count_en,
    output logic             comperator_output,
    output logic [ACC_W-1:0] sum_out,
    output logic             done,
    output logic             ovf
);

    logic [N_W-1:0]   n_reg;
    logic [N_W-1:0]   i_cnt;
    logic [ACC_W-1:0] acc;
    logic [FRAC_W:0]  recip;
    logic [ACC_W:0]   sum_ext;
    logic             add_ok;
    logic             carry;

    hsum_recip_rom #(
        .N_W    (N_W),
        .FRAC_W (FRAC_W)
    ) u_rom (
        .addr  (i_cnt),
        .recip (recip)
    );

    // Compare is taken straight from the registers so the FSM can leave the
    // adding state on the very cycle the last term goes in.
    assign comperator_output = (i_cnt >= n_reg);

    assign add_ok  = add_en && (n_reg != '0);
    assign sum_ext = {1'b0, acc} + (ACC_W+1)'(recip);
    assign carry   = sum_ext[ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg <= '0;
        end else if (reset_n) begin
            n_reg <= '0;
        end else if (n_en) begin
            n_reg <= n_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cnt <= N_W'(1);
        end else if (reset_datapath) begin
            i_cnt <= N_W'(1);
        end else if (count_en) begin
            i_cnt <= i_cnt + N_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (reset_datapath) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (add_ok) begin
`ifdef HSUM_SAT_EN
            acc <= carry ? '1 : sum_ext[ACC_W-1:0];
`else
            acc <= sum_ext[ACC_W-1:0];
`endif
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= add_en & comperator_output;
        end
    end

    assign sum_out = acc;

endmodule

// File: tb/tb_harmonic_datapath.sv
// Directed bench for harmonic_datapath: the bench plays the sequencer FSM.
// Two instances share stimulus: default widths and INT_W=2 for the overflow case.
module tb_harmonic_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  n_in;
    logic        reset_datapath;
    logic        reset_n;
    logic        n_en;
    logic        add_en;
    logic        count_en;

    logic        comp_a;
    logic [19:0] sum_a;
    logic        done_a;
    logic        ovf_a;

    logic        comp_b;
    logic [17:0] sum_b;
    logic        done_b;
    logic        ovf_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    harmonic_datapath u_dut (
        .clk               (clk),
        .rst               (rst),
        .n_in              (n_in),
        .reset_datapath    (reset_datapath),
        .reset_n           (reset_n),
        .n_en              (n_en),
        .add_en            (add_en),
        .count_en          (count_en),
        .comperator_output (comp_a),
        .sum_out           (sum_a),
        .done              (done_a),
        .ovf               (ovf_a)
    );

    harmonic_datapath #(.INT_W(2)) u_ovf (
        .clk               (clk),
        .rst               (rst),
        .n_in              (n_in),
        .reset_datapath    (reset_datapath),
        .reset_n           (reset_n),
        .n_en              (n_en),
        .add_en            (add_en),
        .count_en          (count_en),
        .comperator_output (comp_b),
        .sum_out           (sum_b),
        .done              (done_b),
        .ovf               (ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset_datapath = 1'b0;
        reset_n        = 1'b0;
        n_en           = 1'b0;
        add_en         = 1'b0;
        count_en       = 1'b0;
    endtask

    // One full run as the FSM would drive it; reports load-to-done latency.
    task automatic run_n(input logic [7:0] n, input string tag, output int lat);
        int  guard;
        bit  seen;
        @(posedge clk); #1;
        idle_inputs();
        reset_datapath = 1'b1;
        n_en           = 1'b1;
        n_in           = n;
        @(posedge clk); #1;
        idle_inputs();
        add_en   = 1'b1;
        count_en = 1'b1;
        lat      = 1;
        seen     = 1'b0;
        for (guard = 0; guard < 300; guard++) begin
            @(negedge clk);
            if (guard == 0 && n <= 8'd1) begin
                check({tag, "_comp_first"}, 32'(comp_a), 32'd1);
            end
            if (comp_a) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_comp_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        lat++;
        @(negedge clk);
        check({tag, "_done_hi"}, 32'(done_a), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_lo"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] model;

        rst  = 1'b1;
        n_in = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_sum",  32'(sum_a),  32'h0);
        check("rst_ovf",  32'(ovf_a),  32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_comp", 32'(comp_a), 32'h1);

        run_n(8'd1, "n1", lat);
        check("n1_sum", 32'(sum_a), 32'h10000);
        check("n1_lat", 32'(lat), 32'd2);

        run_n(8'd4, "n4", lat);
        check("n4_sum", 32'(sum_a), 32'h21555);
        check("n4_ovf", 32'(ovf_a), 32'h0);
        check("n4_lat", 32'(lat), 32'd5);

        run_n(8'd0, "n0", lat);
        check("n0_sum", 32'(sum_a), 32'h0);
        check("n0_lat", 32'(lat), 32'd2);

        // Sum holds after done until the next clear.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("n0_hold", 32'(sum_a), 32'h0);

        run_n(8'd31, "n31", lat);
        check("n31_lat", 32'(lat), 32'd32);
        check("n31_ovf_b", 32'(ovf_b), 32'h1);
`ifdef HSUM_SAT_EN
        check("n31_sum_b", 32'(sum_b), 32'h3FFFF);
`else
        check("n31_sum_b", 32'(sum_b), 32'h006ED);
`endif
        check("n31_ovf_a", 32'(ovf_a), 32'h0);

        run_n(8'd255, "n255", lat);
        model = 0;
        for (int k = 1; k <= 255; k++) begin
            model += 32'h10000 / k;
        end
        check("n255_sum", 32'(sum_a), model);
        check("n255_lat", 32'(lat), 32'd256);
        check("n255_ovf", 32'(ovf_a), 32'h0);

        run_n(8'd2, "n2", lat);
        check("n2_sum",   32'(sum_a), 32'h18000);
        check("n2_ovf",   32'(ovf_a), 32'h0);
        check("n2_sum_b", 32'(sum_b), 32'h18000);
        check("n2_ovf_b", 32'(ovf_b), 32'h0);

        // reset_n clears n only: compare goes true, sum untouched.
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rn_comp", 32'(comp_a), 32'h1);
        check("rn_sum",  32'(sum_a),  32'h18000);

        // Asynchronous reset in the middle of an n=4 run.
        @(posedge clk); #1;
        reset_datapath = 1'b1;
        n_en           = 1'b1;
        n_in           = 8'd4;
        @(posedge clk); #1;
        idle_inputs();
        add_en   = 1'b1;
        count_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_comp_pre", 32'(comp_a), 32'h0);
        check("mid_sum_pre",  32'(sum_a),  32'h18000);
        #2;
        rst = 1'b1;
        #1;
        check("mid_sum",  32'(sum_a),  32'h0);
        check("mid_ovf",  32'(ovf_a),  32'h0);
        check("mid_done", 32'(done_a), 32'h0);
        check("mid_comp", 32'(comp_a), 32'h1);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        run_n(8'd2, "post", lat);
        check("post_sum", 32'(sum_a), 32'h18000);
        check("post_lat", 32'(lat), 32'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
